// File: rtl/clk_div_multi_if.sv
// Control/status bundle for the multi-channel clock divider: run enables,
// phase sync, divisor writes, and the per-channel clock/strobe/update flags.
interface clk_div_multi_if #(
  parameter int NCH   = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]   en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_val;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   clk_out_r;
  logic [NCH-1:0]   clk_out_f;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   upd;

  modport master (
    output en, sync, wr_en, wr_ch, wr_val,
    input  clk_out, clk_out_r, clk_out_f, pend, upd
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_val,
    output clk_out, clk_out_r, clk_out_f, pend, upd
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider with runtime half-period, edge strobes and
// glitch-free divisor updates applied at falling edges, on disable or on sync.
module clk_div_multi #(
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 1
) (
  input logic             clk,
  input logic             rst,
  clk_div_multi_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_HALF);

  logic [NCH-1:0] clk_vec;
  logic [NCH-1:0] rise_vec;
  logic [NCH-1:0] fall_vec;
  logic [NCH-1:0] pend_vec;
  logic [NCH-1:0] upd_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] act_reg;
      logic [CNT_W-1:0] shd_reg;
      logic             clk_reg;
      logic             pend_reg;
      logic             upd_reg;
      logic             tc;
      logic             fall;
      logic             wr_hit;
      logic             apply;

      // sync suppresses the terminal count so no strobe fires in the sync cycle
      assign tc     = bus.en[gi] & ~bus.sync & (cnt_reg == act_reg);
      assign fall   = tc & clk_reg;
      assign wr_hit = bus.wr_en & (bus.wr_ch == CH_W'(gi));
      // Every apply point coincides with cnt being cleared, so cnt never exceeds act
      assign apply  = pend_reg & (~bus.en[gi] | bus.sync | fall);

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          act_reg  <= DEF_VAL;
          shd_reg  <= DEF_VAL;
          clk_reg  <= 1'b0;
          pend_reg <= 1'b0;
          upd_reg  <= 1'b0;
        end else begin
          upd_reg <= apply;
          if (apply) begin
            act_reg <= shd_reg;
          end
          if (wr_hit) begin
            shd_reg  <= bus.wr_val;
            pend_reg <= 1'b1;
          end else if (apply) begin
            pend_reg <= 1'b0;
          end
          if (~bus.en[gi] | bus.sync) begin
            cnt_reg <= '0;
            clk_reg <= 1'b0;
          end else if (tc) begin
            cnt_reg <= '0;
            clk_reg <= ~clk_reg;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign clk_vec[gi]  = clk_reg;
      assign rise_vec[gi] = tc & ~clk_reg;
      assign fall_vec[gi] = fall;
      assign pend_vec[gi] = pend_reg;
      assign upd_vec[gi]  = upd_reg;
    end
  endgenerate

  assign bus.clk_out   = clk_vec;
  assign bus.clk_out_r = rise_vec;
  assign bus.clk_out_f = fall_vec;
  assign bus.pend      = pend_vec;
  assign bus.upd       = upd_vec;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a vector table for free-running and
// boundary-apply behaviour, plus hand sequences for disable, sync, bad writes and reset.
module tb_clk_div_multi;

  logic clk;
  logic rst;

  clk_div_multi_if #(.NCH(4), .CH_W(2), .CNT_W(8)) bus ();
  clk_div_multi_if #(.NCH(3), .CH_W(2), .CNT_W(8)) sm ();

  clk_div_multi #(.NCH(4), .CH_W(2), .CNT_W(8), .DEF_HALF(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clk_div_multi #(.NCH(3), .CH_W(2), .CNT_W(8), .DEF_HALF(1)) dut_sm (
    .clk (clk),
    .rst (rst),
    .bus (sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] en;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_val;
    logic [3:0] e_clk;
    logic [3:0] e_r;
    logic [3:0] e_f;
    logic [3:0] e_pend;
    logic [3:0] e_upd;
  } vec_t;

  vec_t tbl [21];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [3:0] s_clk [6];
  logic [3:0] s_r   [6];
  logic [3:0] s_f   [6];

  function automatic vec_t mk(input logic [3:0] e, input logic we, input logic [7:0] wv,
                              input logic [3:0] c, input logic [3:0] r, input logic [3:0] f,
                              input logic [3:0] p, input logic [3:0] u);
    vec_t v;
    v.en     = e;
    v.wr_en  = we;
    v.wr_ch  = 2'd0;
    v.wr_val = wv;
    v.e_clk  = c;
    v.e_r    = r;
    v.e_f    = f;
    v.e_pend = p;
    v.e_upd  = u;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  // One cycle: inputs change on the negedge, outputs sampled 1 time unit later
  task automatic set_in(input logic r, input logic [3:0] e, input logic s, input logic we,
                        input logic [1:0] wc, input logic [7:0] wv);
    @(negedge clk);
    rst        = r;
    bus.en     = e;
    bus.sync   = s;
    bus.wr_en  = we;
    bus.wr_ch  = wc;
    bus.wr_val = wv;
    #1;
  endtask

  task automatic do_reset;
    sm.en     = '0;
    sm.sync   = 1'b0;
    sm.wr_en  = 1'b0;
    sm.wr_ch  = '0;
    sm.wr_val = '0;
    set_in(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    set_in(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.en     = '0;
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_val = '0;

    // Default H=1 free-running, then a ch0 write of H=3 during a high phase
    tbl[0]  = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[1]  = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    tbl[2]  = mk(4'hF, 1'b0, 8'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[3]  = mk(4'hF, 1'b0, 8'd0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[4]  = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[5]  = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    tbl[6]  = mk(4'hF, 1'b0, 8'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[7]  = mk(4'hF, 1'b0, 8'd0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[8]  = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[9]  = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    tbl[10] = mk(4'hF, 1'b1, 8'd3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[11] = mk(4'hF, 1'b0, 8'd0, 4'hF, 4'h0, 4'hF, 4'h1, 4'h0);
    tbl[12] = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    tbl[13] = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
    tbl[14] = mk(4'hF, 1'b0, 8'd0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[15] = mk(4'hF, 1'b0, 8'd0, 4'hE, 4'h1, 4'hE, 4'h0, 4'h0);
    tbl[16] = mk(4'hF, 1'b0, 8'd0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[17] = mk(4'hF, 1'b0, 8'd0, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0);
    tbl[18] = mk(4'hF, 1'b0, 8'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[19] = mk(4'hF, 1'b0, 8'd0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[20] = mk(4'hF, 1'b0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // After sync: ch0 (H=2) rises 3 cycles later, ch2 (H=5) 6 cycles later
    s_clk = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    s_r   = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4};
    s_f   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};

    do_reset;
    chk("rst_clk",  0, bus.clk_out,   4'h0);
    chk("rst_r",    0, bus.clk_out_r, 4'h0);
    chk("rst_f",    0, bus.clk_out_f, 4'h0);
    chk("rst_pend", 0, bus.pend,      4'h0);
    chk("rst_upd",  0, bus.upd,       4'h0);
    chk("rst_sm_pend", 0, {1'b0, sm.pend}, 4'h0);

    for (int i = 0; i < 21; i++) begin
      set_in(1'b0, tbl[i].en, 1'b0, tbl[i].wr_en, tbl[i].wr_ch, tbl[i].wr_val);
      chk("tbl_clk",  i, bus.clk_out,   tbl[i].e_clk);
      chk("tbl_r",    i, bus.clk_out_r, tbl[i].e_r);
      chk("tbl_f",    i, bus.clk_out_f, tbl[i].e_f);
      chk("tbl_pend", i, bus.pend,      tbl[i].e_pend);
      chk("tbl_upd",  i, bus.upd,       tbl[i].e_upd);
    end

    // Disable ch1 mid-high phase, write H=0 while parked, re-enable at clk/2
    do_reset;
    set_in(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("dis_r", 1, bus.clk_out_r, 4'h0);
    set_in(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("dis_r", 2, bus.clk_out_r, 4'h2);
    set_in(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("dis_clk", 3, bus.clk_out, 4'h2);
    set_in(1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 8'd0);
    chk("dis_f", 4, bus.clk_out_f, 4'h0);
    chk("dis_r", 4, bus.clk_out_r, 4'h0);
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("dis_clk",  5, bus.clk_out, 4'h0);
    chk("dis_pend", 5, bus.pend,    4'h2);
    chk("dis_upd",  5, bus.upd,     4'h0);
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("dis_upd",  6, bus.upd,     4'h2);
    chk("dis_pend", 6, bus.pend,    4'h0);
    for (int k = 7; k <= 8; k++) begin
      set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("dis_upd", k, bus.upd,     4'h0);
      chk("dis_clk", k, bus.clk_out, 4'h0);
    end
    set_in(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("ren_r", 9, bus.clk_out_r, 4'h2);
    set_in(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("ren_clk", 10, bus.clk_out,   4'h2);
    chk("ren_f",   10, bus.clk_out_f, 4'h2);
    set_in(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("ren_clk", 11, bus.clk_out,   4'h0);
    chk("ren_r",   11, bus.clk_out_r, 4'h2);
    set_in(1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("ren_f", 12, bus.clk_out_f, 4'h2);

    // ch0 H=2 and ch2 H=5 applied while disabled, run, then phase-align with sync
    do_reset;
    set_in(1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 8'd2);
    set_in(1'b0, 4'h0, 1'b0, 1'b1, 2'd2, 8'd5);
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("syn_upd", 3, bus.upd, 4'h1);
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("syn_upd", 4, bus.upd, 4'h4);
    repeat (5) set_in(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 8'd0);
    set_in(1'b0, 4'h5, 1'b1, 1'b0, 2'd0, 8'd0);
    chk("syn_r",   0, bus.clk_out_r, 4'h0);
    chk("syn_f",   0, bus.clk_out_f, 4'h0);
    chk("syn_clk", 0, bus.clk_out,   4'h1);
    for (int k = 0; k < 6; k++) begin
      set_in(1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("syn_clk", k + 1, bus.clk_out & 4'h5, s_clk[k]);
      chk("syn_r",   k + 1, bus.clk_out_r,      s_r[k]);
      chk("syn_f",   k + 1, bus.clk_out_f,      s_f[k]);
    end

    // Out-of-range channel write on the 3-channel instance must be ignored
    do_reset;
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    sm.en     = 3'b111;
    sm.wr_en  = 1'b1;
    sm.wr_ch  = 2'd3;
    sm.wr_val = 8'd7;
    #1;
    chk("oor_r", 1, {1'b0, sm.clk_out_r}, 4'h0);
    for (int k = 2; k <= 8; k++) begin
      set_in(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
      sm.wr_en = 1'b0;
      #1;
      chk("oor_pend", k, {1'b0, sm.pend},      4'h0);
      chk("oor_upd",  k, {1'b0, sm.upd},       4'h0);
      chk("oor_r",    k, {1'b0, sm.clk_out_r}, (k == 2 || k == 6) ? 4'h7 : 4'h0);
      chk("oor_f",    k, {1'b0, sm.clk_out_f}, (k == 4 || k == 8) ? 4'h7 : 4'h0);
    end
    sm.en = '0;

    // Write coinciding with an apply, then reset discards the pending value
    do_reset;
    set_in(1'b0, 4'h1, 1'b0, 1'b1, 2'd0, 8'd2);
    chk("wa_r", 1, bus.clk_out_r, 4'h0);
    set_in(1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_r",    2, bus.clk_out_r, 4'h1);
    chk("wa_pend", 2, bus.pend,      4'h1);
    set_in(1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_clk", 3, bus.clk_out, 4'h1);
    set_in(1'b0, 4'h1, 1'b0, 1'b1, 2'd0, 8'd4);
    chk("wa_f",    4, bus.clk_out_f, 4'h1);
    chk("wa_pend", 4, bus.pend,      4'h1);
    chk("wa_upd",  4, bus.upd,       4'h0);
    set_in(1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_upd",  5, bus.upd,     4'h1);
    chk("wa_pend", 5, bus.pend,    4'h1);
    chk("wa_clk",  5, bus.clk_out, 4'h0);
    set_in(1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_r",   6, bus.clk_out_r, 4'h0);
    chk("wa_upd", 6, bus.upd,       4'h0);
    set_in(1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_r", 7, bus.clk_out_r, 4'h1);
    set_in(1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_clk", 8, bus.clk_out, 4'h1);
    set_in(1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_pend", 9, bus.pend,      4'h0);
    chk("wa_upd",  9, bus.upd,       4'h0);
    chk("wa_clk",  9, bus.clk_out,   4'h0);
    chk("wa_r",    9, bus.clk_out_r, 4'h0);
    set_in(1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("wa_r", 10, bus.clk_out_r, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
